i2c_req_arbiter: RTL and testbench

- Shares one I2C master engine among N_REQ requesters.
- Arbitrates round-robin and latches the winner's command (device address, R/W, register address, write data).
- Launches the master with a one-cycle start pulse, waits for completion, retries on NACK, and returns a per-requester response.
- Sits between system-side register agents and the I2C master/bit engine.

---
 rtl/i2c_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_req_arbiter
//
// Shares one I2C master engine among N_REQ system-side requesters. A
// round-robin arbiter picks a winner, its command is latched onto the m_*
// bus, the master is launched with a one-cycle m_start pulse, and the
// completion (with NACK retries) is returned to the owner as a one-cycle
// rsp_valid pulse.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   RETRY_MAX    extra attempts after a NACK (0..7)
//   TIMEOUT_CYC  WAIT cycles before abort (only with I2C_ARB_TIMEOUT_EN)
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   Defined   : a 16-bit WAIT counter aborts the transaction with rsp_err=1
//               after TIMEOUT_CYC cycles without m_done.
//   Undefined : WAIT holds until m_done.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   req, req_rw       per-requester request level and direction (1=read)
//   req_dev           7-bit device address, requester i at [7i+6:7i]
//   req_reg           8-bit register address, requester i at [8i+7:8i]
//   req_wdata         8-bit write data, requester i at [8i+7:8i]
//   gnt               one-hot owner of the current transaction
//   rsp_valid         one-cycle completion pulse to the owner
//   rsp_err           with rsp_valid: NACK after all retries (or timeout)
//   rsp_rdata         with rsp_valid: read data, 0 for writes/errors
//   m_start           one-cycle launch pulse to the master
//   m_rw/m_dev/m_reg/m_wdata  latched command, stable ISSUE through WAIT
//   m_busy            master engaged; launch is held off while high
//   m_done, m_nack    one-cycle completion and its NACK flag
//   m_rdata           read data, valid with m_done
//   busy              high in every state except IDLE
// -----------------------------------------------------------------------------
module i2c_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int RETRY_MAX   = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [7*N_REQ-1:0]   req_dev,
  input  logic [8*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_err,
  output logic [7:0]           rsp_rdata,
  output logic                 m_start,
  output logic                 m_rw,
  output logic [6:0]           m_dev,
  output logic [7:0]           m_reg,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata,
  output logic                 busy
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || RETRY_MAX < 0 || RETRY_MAX > 7 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_params
    $error("i2c_req_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr, ptr_next;
  logic [2:0]        retry, retry_next;
  logic [N_REQ-1:0]  gnt_next, rsp_valid_next;
  logic              rsp_err_next;
  logic [7:0]        rsp_rdata_next;
  logic              m_start_next, m_rw_next;
  logic [6:0]        m_dev_next;
  logic [7:0]        m_reg_next, m_wdata_next;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC - 1);
  logic [15:0]       wait_cnt, wait_cnt_next;
`endif

  // Round-robin winner: the first set req bit at or above ptr, wrapping.
  // Scanning offsets from high to low lets the lowest offset win last.
  logic              win_found;
  logic [PW-1:0]     win;
  int                scan_idx;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (req[PW'(scan_idx)]) begin
        win_found = 1'b1;
        win       = PW'(scan_idx);
      end
    end
  end

  // Winner's command fields, selected with constant part-selects.
  logic [N_REQ-1:0]  win_onehot;
  logic              sel_rw;
  logic [6:0]        sel_dev;
  logic [7:0]        sel_reg, sel_wdata;

  always_comb begin
    win_onehot = '0;
    sel_rw     = 1'b0;
    sel_dev    = '0;
    sel_reg    = '0;
    sel_wdata  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) begin
        win_onehot[i] = 1'b1;
        sel_rw        = req_rw[i];
        sel_dev       = req_dev[7*i +: 7];
        sel_reg       = req_reg[8*i +: 8];
        sel_wdata     = req_wdata[8*i +: 8];
      end
    end
  end

  // Next-state and output logic.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    retry_next     = retry;
    gnt_next       = gnt;
    rsp_valid_next = '0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    m_start_next   = 1'b0;
    m_rw_next      = m_rw;
    m_dev_next     = m_dev;
    m_reg_next     = m_reg;
    m_wdata_next   = m_wdata;
`ifdef I2C_ARB_TIMEOUT_EN
    wait_cnt_next  = wait_cnt;
`endif

    unique case (state)
      S_IDLE: begin
        if (|req) state_next = S_ARB;
      end

      S_ARB: begin
        // A requester may withdraw between IDLE and ARB; then nobody wins.
        if (win_found) begin
          gnt_next     = win_onehot;
          m_rw_next    = sel_rw;
          m_dev_next   = sel_dev;
          m_reg_next   = sel_reg;
          m_wdata_next = sel_wdata;
          ptr_next     = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          retry_next   = '0;
          state_next   = S_ISSUE;
        end else begin
          state_next   = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (!m_busy) begin
          m_start_next  = 1'b1;
          state_next    = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
        end
      end

      S_WAIT: begin
        if (m_done) begin
          if (m_nack && (retry < 3'(RETRY_MAX))) begin
            retry_next = retry + 3'd1;
            state_next = S_ISSUE;
          end else begin
            rsp_valid_next = gnt;
            rsp_err_next   = m_nack;
            rsp_rdata_next = (m_rw && !m_nack) ? m_rdata : 8'h00;
            state_next     = S_RESP;
          end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LIM) begin
          rsp_valid_next = gnt;
          rsp_err_next   = 1'b1;
          state_next     = S_RESP;
        end else begin
          wait_cnt_next  = wait_cnt + 16'd1;
        end
`endif
      end

      S_RESP: begin
        gnt_next   = '0;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      retry     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_start   <= 1'b0;
      m_rw      <= 1'b0;
      m_dev     <= '0;
      m_reg     <= '0;
      m_wdata   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      retry     <= retry_next;
      gnt       <= gnt_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
      m_start   <= m_start_next;
      m_rw      <= m_rw_next;
      m_dev     <= m_dev_next;
      m_reg     <= m_reg_next;
      m_wdata   <= m_wdata_next;
`ifdef I2C_ARB_TIMEOUT_EN
      wait_cnt  <= wait_cnt_next;
`endif
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_req_arbiter
//
// Self-checking bench for i2c_req_arbiter. A behavioural master answers each
// m_start after a programmable latency, optionally NACKing. Expected
// responses are queued when a request is driven; a monitor compares each
// m_start command and each rsp_valid pulse against the queue head. Scenario
// tasks add their own inline timing and reset checks.
// -----------------------------------------------------------------------------
module tb_i2c_req_arbiter;

  localparam int N_REQ       = 4;
  localparam int RETRY_MAX   = 2;
  localparam int TIMEOUT_CYC = 100;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req, req_rw;
  logic [7*N_REQ-1:0]   req_dev;
  logic [8*N_REQ-1:0]   req_reg, req_wdata;
  logic [N_REQ-1:0]     gnt, rsp_valid;
  logic                 rsp_err;
  logic [7:0]           rsp_rdata;
  logic                 m_start, m_rw;
  logic [6:0]           m_dev;
  logic [7:0]           m_reg, m_wdata;
  logic                 m_busy, m_done, m_nack;
  logic [7:0]           m_rdata;
  logic                 busy;

  i2c_req_arbiter #(
    .N_REQ      (N_REQ),
    .RETRY_MAX  (RETRY_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_rw   (req_rw),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .m_start  (m_start),
    .m_rw     (m_rw),
    .m_dev    (m_dev),
    .m_reg    (m_reg),
    .m_wdata  (m_wdata),
    .m_busy   (m_busy),
    .m_done   (m_done),
    .m_nack   (m_nack),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] owner;
    logic             err;
    logic [7:0]       rdata;
    int               starts;
    logic             rw;
    logic [6:0]       dev;
    logic [7:0]       regad;
    logic [7:0]       wdata;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks    = 0;
  int         n_fail      = 0;
  int         rsp_count   = 0;
  int         starts_seen = 0;

  // Master model controls.
  int         nack_left   = 0;
  int         mst_lat     = 3;
  bit         mst_respond = 1'b1;
  logic [7:0] mst_rdata   = 8'h00;

  // Behavioural master: answers each m_start after mst_lat cycles.
  always begin
    @(negedge clk);
    m_done = 1'b0;
    m_nack = 1'b0;
    if (m_start === 1'b1 && mst_respond) begin
      repeat (mst_lat) @(negedge clk);
      m_done  = 1'b1;
      m_nack  = (nack_left > 0);
      if (nack_left > 0) nack_left--;
      m_rdata = mst_rdata;
    end
  end

  // Monitor: command on each launch and each response against the queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m_start === 1'b1) begin
        starts_seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL start_unexpected: m_start seen with no pending request");
        end else if (gnt !== sb[0].owner || m_rw !== sb[0].rw || m_dev !== sb[0].dev ||
                     m_reg !== sb[0].regad || m_wdata !== sb[0].wdata) begin
          n_fail++;
          $display("FAIL start_cmd: got gnt=%b rw=%b dev=%h reg=%h wdata=%h, expected gnt=%b rw=%b dev=%h reg=%h wdata=%h",
                   gnt, m_rw, m_dev, m_reg, m_wdata,
                   sb[0].owner, sb[0].rw, sb[0].dev, sb[0].regad, sb[0].wdata);
        end
      end
      if (rsp_valid !== '0) begin
        rsp_count++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with no pending request", rsp_valid);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_valid !== mon_e.owner || rsp_err !== mon_e.err ||
              rsp_rdata !== mon_e.rdata || starts_seen != mon_e.starts) begin
            n_fail++;
            $display("FAIL rsp: got valid=%b err=%b rdata=%h starts=%0d, expected valid=%b err=%b rdata=%h starts=%0d",
                     rsp_valid, rsp_err, rsp_rdata, starts_seen,
                     mon_e.owner, mon_e.err, mon_e.rdata, mon_e.starts);
          end
        end
        starts_seen = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic rw, input logic [6:0] dev,
                          input logic [7:0] regad, input logic [7:0] wdata);
    req_rw[lane]            = rw;
    req_dev[7*lane +: 7]    = dev;
    req_reg[8*lane +: 8]    = regad;
    req_wdata[8*lane +: 8]  = wdata;
  endtask

  task automatic push_exp(input int lane, input logic err, input logic [7:0] rdata,
                          input int starts);
    exp_t e;
    e.owner       = '0;
    e.owner[lane] = 1'b1;
    e.err         = err;
    e.rdata       = rdata;
    e.starts      = starts;
    e.rw          = req_rw[lane];
    e.dev         = req_dev[7*lane +: 7];
    e.regad       = req_reg[8*lane +: 8];
    e.wdata       = req_wdata[8*lane +: 8];
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int cyc = 0;
    while (rsp_count < target && cyc < budget) begin
      step();
      cyc++;
    end
    if (rsp_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d responses after %0d cycles, required %0d", name, rsp_count, cyc, target);
    end
  endtask

  task automatic wait_start(input string name);
    int cyc = 0;
    while (m_start !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    if (m_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: m_start=%b after %0d cycles, required 1", name, m_start, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({gnt, rsp_valid, rsp_err, rsp_rdata, m_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: gnt=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h m_start=%b, required all 0",
               gnt, rsp_valid, rsp_err, rsp_rdata, m_start);
    end
    n_checks++;
    if ({m_rw, m_dev, m_reg, m_wdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_cmd: m_rw=%b m_dev=%h m_reg=%h m_wdata=%h busy=%b, required all 0",
               m_rw, m_dev, m_reg, m_wdata, busy);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b gnt=%b, required 0/0", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int base = rsp_count;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 1'b0, 7'(16 + i), 8'(32 + i), 8'(48 + i));
    for (int i = 0; i < N_REQ; i++) push_exp(i, 1'b0, 8'h00, 1);
    mst_rdata = 8'hC3;
    req = '1;
    wait_rsp(base + N_REQ, 400, "rr_four");
    // Pointer wrapped past 3 back to 0, so lane 0 wins over lane 3.
    req = 4'b1001;
    push_exp(0, 1'b0, 8'h00, 1);
    wait_rsp(base + N_REQ + 1, 100, "rr_wrap");
    req = '0;
    step();
    n_checks++;
    if (gnt !== '0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL rr_release: gnt=%b rsp_valid=%b, required 0/0", gnt, rsp_valid);
    end
  endtask

  task automatic test_single_write();
    int base = rsp_count;
    set_lane(1, 1'b0, 7'h64, 8'hA5, 8'h3C);
    push_exp(1, 1'b0, 8'h00, 1);
    mst_rdata = 8'hEE;
    req = 4'b0010;
    step();
    n_checks++;
    if (gnt !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_arb: gnt=%b busy=%b, required 0000/1", gnt, busy);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0010 || m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_gnt: gnt=%b m_start=%b, required 0010/0", gnt, m_start);
    end
    step();
    n_checks++;
    if (m_start !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_start: m_start=%b, required 1", m_start);
    end
    wait_rsp(base + 1, 50, "sw_rsp");
    req = '0;
    step();
    n_checks++;
    if (gnt !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_done: gnt=%b rsp_valid=%b busy=%b, required 0/0/0", gnt, rsp_valid, busy);
    end
  endtask

  task automatic test_nack_retry();
    int base = rsp_count;
    // Every attempt NACKed: initial try plus RETRY_MAX retries.
    set_lane(3, 1'b0, 7'h3A, 8'h44, 8'h55);
    nack_left = RETRY_MAX + 1;
    mst_rdata = 8'h77;
    push_exp(3, 1'b1, 8'h00, RETRY_MAX + 1);
    req = 4'b1000;
    wait_rsp(base + 1, 150, "nack_all");
    req = '0;
    step();
    // Only the first attempt NACKed, read succeeds on the retry.
    nack_left = 1;
    set_lane(0, 1'b1, 7'h21, 8'h01, 8'hFF);
    mst_rdata = 8'h99;
    push_exp(0, 1'b0, 8'h99, 2);
    req = 4'b0001;
    wait_rsp(base + 2, 150, "nack_once");
    req = '0;
    step();
    nack_left = 0;
  endtask

  task automatic test_read();
    int base = rsp_count;
    set_lane(2, 1'b1, 7'h50, 8'h0F, 8'hAA);
    push_exp(2, 1'b0, 8'h5A, 1);
    mst_rdata = 8'h5A;
    mst_lat   = 6;
    req = 4'b0100;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL rd_gnt: gnt=%b, required 0100", gnt);
    end
    // Fields changed after ARB must not reach the m_* bus.
    set_lane(2, 1'b0, 7'h7F, 8'hFF, 8'h00);
    wait_start("rd_start");
    step();
    req = '0;
    wait_rsp(base + 1, 50, "rd_rsp");
    step();
    n_checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_done: gnt=%b busy=%b, required 0/0", gnt, busy);
    end
    mst_lat = 3;
  endtask

  task automatic test_busy_master();
    int base = rsp_count;
    bit quiet = 1'b1;
    m_busy = 1'b1;
    set_lane(0, 1'b0, 7'h2B, 8'h11, 8'h22);
    push_exp(0, 1'b0, 8'h00, 1);
    req = 4'b0001;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL busy_gnt: gnt=%b, required 0001", gnt);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_start !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL busy_hold: m_start pulsed while m_busy=1, required none");
    end
    m_busy = 1'b0;
    step();
    n_checks++;
    if (m_start !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_launch: m_start=%b, required 1", m_start);
    end
    step();
    n_checks++;
    if (m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_single: m_start=%b, required 0", m_start);
    end
    wait_rsp(base + 1, 50, "busy_rsp");
    req = '0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int  base;
    bit  silent = 1'b1;
    mst_respond = 1'b0;
    set_lane(2, 1'b1, 7'h0C, 8'h9D, 8'h6E);
    push_exp(2, 1'b0, 8'h00, 1);
    req = 4'b0100;
    wait_start("rst_start");
    repeat (4) step();
    rst = 1'b1;
    req = '0;
    step();
    n_checks++;
    if ({gnt, rsp_valid, rsp_err, rsp_rdata, m_start, busy} !== '0 ||
        {m_rw, m_dev, m_reg, m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: gnt=%b rsp_valid=%b m_start=%b busy=%b m_dev=%h m_reg=%h, required all 0",
               gnt, rsp_valid, m_start, busy, m_dev, m_reg);
    end
    rst = 1'b0;
    sb.delete();
    starts_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== '0) silent = 1'b0;
    end
    n_checks++;
    if (!silent) begin
      n_fail++;
      $display("FAIL rst_norsp: rsp_valid pulsed after abort, required none");
    end
    // Pointer was 3 before reset; cleared to 0 means lane 1 beats lane 3.
    mst_respond = 1'b1;
    base = rsp_count;
    set_lane(1, 1'b0, 7'h41, 8'h42, 8'h43);
    set_lane(3, 1'b0, 7'h71, 8'h72, 8'h73);
    push_exp(1, 1'b0, 8'h00, 1);
    req = 4'b1010;
    wait_rsp(base + 1, 50, "rst_ptr");
    req = '0;
    step();
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int base = rsp_count;
    int cyc  = 0;
    mst_respond = 1'b0;
    set_lane(1, 1'b1, 7'h55, 8'h66, 8'h77);
    push_exp(1, 1'b1, 8'h00, 1);
    req = 4'b0010;
    wait_start("to_start");
    while (rsp_count < base + 1 && cyc < 3 * TIMEOUT_CYC) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL to_cycles: response after %0d WAIT cycles, required %0d", cyc, TIMEOUT_CYC);
    end
    req = '0;
    step();
    mst_respond = 1'b1;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_rw    = '0;
    req_dev   = '0;
    req_reg   = '0;
    req_wdata = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_nack    = 1'b0;
    m_rdata   = '0;

    test_reset();
    test_round_robin();
    test_single_write();
    test_nack_retry();
    test_read();
    test_busy_master();
    test_reset_mid_wait();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected responses never arrived, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
